xcvr_lane_init_ctrl: RTL and testbench
======================================

Name: xcvr_lane_init_ctrl

Overview:
Fabric-clocked reset/initialisation sequencer that sits directly downstream of the TX PLL wrapper. It consumes the PLL's PLL_LOCK and sequences the transceiver lane's PMA and PCS asynchronous resets. It then monitors lane clock stability and CDR lock, and reports TX/RX readiness to the digitizer link logic. Loss of PLL lock at any point restarts the whole sequence.

Parameters:
PMA_RST_CYC, 64, cycles both lane resets are held low in RESET_ALL (>=2)
LOCK_STABLE_CYC, 1024, consecutive cycles of synchronised PLL_LOCK=1 required before PMA release (>=1)
TX_CLK_TIMEOUT, 65535, max cycles waiting for TX_CLK_STABLE before restart (>=1)
PCS_SETTLE_CYC, 16, cycles after PCS release before TX_READY (>=1)
CNT_W, 20, width of the shared state counter; all cycle parameters must be < 2**CNT_W

Ports:
CLK  in  1  free-running fabric clock, independent of the PLL
RST  in  1  asynchronous, active-high reset
PLL_LOCK  in  1  TX PLL lock, asynchronous to CLK
TX_CLK_STABLE  in  1  lane TX clock stable, asynchronous
RX_VAL  in  1  lane CDR lock/valid, asynchronous
LANE_PMA_ARST_N  out  1  lane PMA reset, active-low
LANE_PCS_ARST_N  out  1  lane PCS reset, active-low
TX_READY  out  1  TX path operational
RX_READY  out  1  RX path operational
INIT_STATE  out  3  current state encoding, for debug
TIMEOUT_CNT  out  8  TX clock timeout event counter (see Optional Feature)

Behaviour:
- PLL_LOCK, TX_CLK_STABLE and RX_VAL each pass through a 2-FF synchroniser (*_s). Latency from pin to FSM is 2 cycles. Synchronisers reset to 0.
- All outputs are registered. Reset values: both ARST_N=0, TX_READY=0, RX_READY=0, INIT_STATE=0, TIMEOUT_CNT=0. The FSM resets to RESET_ALL with the counter at 0.
- Counter rule: the counter clears on every state entry and increments once per cycle in that state. A state with a dwell of N "lasts N cycles" and transitions when count==N-1.
- States (encoding / outputs / transitions):
- 0 RESET_ALL: PMA_N=0, PCS_N=0. After PMA_RST_CYC cycles -> WAIT_PLL.
- 1 WAIT_PLL: both resets still low. pll_lock_s=1 -> PLL_STABLE.
- 2 PLL_STABLE: counts while pll_lock_s=1. Lock drop -> WAIT_PLL. After LOCK_STABLE_CYC cycles -> RELEASE_PMA.
- 3 RELEASE_PMA: PMA_N=1, PCS_N=0. tx_clk_stable_s=1 -> RELEASE_PCS. After TX_CLK_TIMEOUT cycles without it -> RESET_ALL, which is a timeout event.
- 4 RELEASE_PCS: PMA_N=1, PCS_N=1. After PCS_SETTLE_CYC cycles -> TX_UP.
- 5 TX_UP: TX_READY=1. rx_val_s=1 -> RX_UP.
- 6 RX_UP: TX_READY=1, RX_READY=1. rx_val_s=0 -> TX_UP; RX_READY drops on the next clock. Resets are not touched.
- Encoding 7 is unused; if reached, go -> RESET_ALL.
- Global rule in states 3..6: pll_lock_s=0 -> RESET_ALL. This has priority over every other transition, including a timeout in the same cycle.
- Global rule in states 4..6: tx_clk_stable_s=0 -> RESET_ALL.
- Output update: outputs follow the state registered in the same clock edge. Entering RESET_ALL drives both ARST_N low and TX/RX_READY low on that edge.
- Async RST mid-sequence: returns everything to reset values immediately. The sequence restarts fully on the first CLK edge after RST deasserts.

Optional Feature:
Macro XCVR_INIT_TIMEOUT_CNT_EN.
- Defined: TIMEOUT_CNT is an 8-bit counter that increments on each RELEASE_PMA timeout event. It saturates at 255 and clears only on RST.
- Not defined: no counter logic is built and TIMEOUT_CNT is tied to 0. The port list is identical in both builds.

Test Plan:
- PMA_RST_CYC=4, LOCK_STABLE_CYC=8, PCS_SETTLE_CYC=2, all inputs 1 from reset release -> PMA_N rises 4+1+8 cycles after RST low (+2 sync), PCS_N one cycle later, TX_READY 2 cycles after that, RX_READY next cycle.
- PLL_LOCK glitches low for 1 cycle at count 5 of PLL_STABLE -> returns to WAIT_PLL; PMA release delayed by a full fresh 8-cycle window.
- TX_CLK_STABLE held 0, TX_CLK_TIMEOUT=10 -> PMA_N high exactly 10 cycles then low; INIT_STATE 3->0; with macro, TIMEOUT_CNT=1. Repeat 300 timeouts -> TIMEOUT_CNT=255; without macro -> 0.
- In RX_UP, drop RX_VAL -> RX_READY=0 3 cycles later; TX_READY stays 1; both resets stay 1. Reassert RX_VAL -> RX_READY returns.
- In RX_UP, drop PLL_LOCK -> within 3 cycles both ARST_N=0, TX/RX_READY=0, INIT_STATE=0; full sequence re-runs once lock returns.
- Assert RST during RELEASE_PCS -> all outputs at reset values asynchronously (before the next CLK edge).

Source files
------------

// File: rtl/xcvr_lane_init_ctrl.sv
// Lane reset/initialisation sequencer for a transceiver lane behind the TX PLL.
// Sequences the PMA and PCS resets from PLL lock. Reports TX/RX readiness.
// Restarts the whole sequence on loss of PLL lock or of the lane TX clock.
// Optional build macro XCVR_INIT_TIMEOUT_CNT_EN enables the TX-clock timeout counter.
// Without the macro, TIMEOUT_CNT is tied to zero.
module xcvr_lane_init_ctrl #(
    parameter int unsigned PMA_RST_CYC     = 64,
    parameter int unsigned LOCK_STABLE_CYC = 1024,
    parameter int unsigned TX_CLK_TIMEOUT  = 65535,
    parameter int unsigned PCS_SETTLE_CYC  = 16,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PLL_LOCK,
    input  logic       TX_CLK_STABLE,
    input  logic       RX_VAL,
    output logic       LANE_PMA_ARST_N,
    output logic       LANE_PCS_ARST_N,
    output logic       TX_READY,
    output logic       RX_READY,
    output logic [2:0] INIT_STATE,
    output logic [7:0] TIMEOUT_CNT
);

    typedef enum logic [2:0] {
        StResetAll   = 3'd0,
        StWaitPll    = 3'd1,
        StPllStable  = 3'd2,
        StReleasePma = 3'd3,
        StReleasePcs = 3'd4,
        StTxUp       = 3'd5,
        StRxUp       = 3'd6,
        StUnused     = 3'd7
    } state_e;

    // Terminal count of each timed state (dwell N ends when count == N-1)
    localparam logic [CNT_W-1:0] PmaLast    = CNT_W'(PMA_RST_CYC - 1);
    localparam logic [CNT_W-1:0] LockLast   = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TxToLast   = CNT_W'(TX_CLK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SettleLast = CNT_W'(PCS_SETTLE_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       pll_sync_q, txc_sync_q, rxv_sync_q;
    logic             pll_lock_s, tx_clk_stable_s, rx_val_s;

    // Two-flop synchronisers for the asynchronous lane status inputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pll_sync_q <= 2'b00;
            txc_sync_q <= 2'b00;
            rxv_sync_q <= 2'b00;
        end else begin
            pll_sync_q <= {pll_sync_q[0], PLL_LOCK};
            txc_sync_q <= {txc_sync_q[0], TX_CLK_STABLE};
            rxv_sync_q <= {rxv_sync_q[0], RX_VAL};
        end
    end

    assign pll_lock_s      = pll_sync_q[1];
    assign tx_clk_stable_s = txc_sync_q[1];
    assign rx_val_s        = rxv_sync_q[1];

    // Next-state decode; lock loss outranks every other exit, then TX clock loss
    always_comb begin
        state_d = state_q;
        if ((state_q inside {StReleasePma, StReleasePcs, StTxUp, StRxUp}) && !pll_lock_s) begin
            state_d = StResetAll;
        end else if ((state_q inside {StReleasePcs, StTxUp, StRxUp}) && !tx_clk_stable_s) begin
            state_d = StResetAll;
        end else begin
            unique case (state_q)
                StResetAll:   if (cnt_q == PmaLast) state_d = StWaitPll;
                StWaitPll:    if (pll_lock_s) state_d = StPllStable;
                StPllStable: begin
                    if (!pll_lock_s)            state_d = StWaitPll;
                    else if (cnt_q == LockLast) state_d = StReleasePma;
                end
                StReleasePma: begin
                    if (tx_clk_stable_s)        state_d = StReleasePcs;
                    else if (cnt_q == TxToLast) state_d = StResetAll;
                end
                StReleasePcs: if (cnt_q == SettleLast) state_d = StTxUp;
                StTxUp:       if (rx_val_s) state_d = StRxUp;
                StRxUp:       if (!rx_val_s) state_d = StTxUp;
                StUnused:     state_d = StResetAll;
            endcase
        end
    end

    // State, shared dwell counter and outputs registered from the next state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q         <= StResetAll;
            cnt_q           <= '0;
            LANE_PMA_ARST_N <= 1'b0;
            LANE_PCS_ARST_N <= 1'b0;
            TX_READY        <= 1'b0;
            RX_READY        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
            LANE_PMA_ARST_N <= state_d inside {StReleasePma, StReleasePcs, StTxUp, StRxUp};
            LANE_PCS_ARST_N <= state_d inside {StReleasePcs, StTxUp, StRxUp};
            TX_READY        <= state_d inside {StTxUp, StRxUp};
            RX_READY        <= (state_d == StRxUp);
        end
    end

    assign INIT_STATE = state_q;

`ifdef XCVR_INIT_TIMEOUT_CNT_EN
    logic       timeout_evt;
    logic [7:0] timeout_cnt_q;

    // Same condition that takes RELEASE_PMA back to RESET_ALL on timeout
    assign timeout_evt = (state_q == StReleasePma) && pll_lock_s && !tx_clk_stable_s &&
                         (cnt_q == TxToLast);

    // Saturating timeout event counter, cleared only by RST
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timeout_cnt_q <= 8'd0;
        end else if (timeout_evt && (timeout_cnt_q != 8'hff)) begin
            timeout_cnt_q <= timeout_cnt_q + 8'd1;
        end
    end

    assign TIMEOUT_CNT = timeout_cnt_q;
`else
    assign TIMEOUT_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_xcvr_lane_init_ctrl.sv
// Directed self-checking bench for xcvr_lane_init_ctrl.
// Uses short dwell parameters: PMA 4, lock 8, timeout 10, settle 2.
module tb_xcvr_lane_init_ctrl;

    logic       CLK;
    logic       RST;
    logic       PLL_LOCK;
    logic       TX_CLK_STABLE;
    logic       RX_VAL;
    logic       LANE_PMA_ARST_N;
    logic       LANE_PCS_ARST_N;
    logic       TX_READY;
    logic       RX_READY;
    logic [2:0] INIT_STATE;
    logic [7:0] TIMEOUT_CNT;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef XCVR_INIT_TIMEOUT_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    xcvr_lane_init_ctrl #(
        .PMA_RST_CYC     (4),
        .LOCK_STABLE_CYC (8),
        .TX_CLK_TIMEOUT  (10),
        .PCS_SETTLE_CYC  (2),
        .CNT_W           (20)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .PLL_LOCK        (PLL_LOCK),
        .TX_CLK_STABLE   (TX_CLK_STABLE),
        .RX_VAL          (RX_VAL),
        .LANE_PMA_ARST_N (LANE_PMA_ARST_N),
        .LANE_PCS_ARST_N (LANE_PCS_ARST_N),
        .TX_READY        (TX_READY),
        .RX_READY        (RX_READY),
        .INIT_STATE      (INIT_STATE),
        .TIMEOUT_CNT     (TIMEOUT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the edge
    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic pma, input logic pcs,
                              input logic tx, input logic rx, input logic [2:0] st);
        check({tag, ".pma"}, 32'(LANE_PMA_ARST_N), 32'(pma));
        check({tag, ".pcs"}, 32'(LANE_PCS_ARST_N), 32'(pcs));
        check({tag, ".tx"}, 32'(TX_READY), 32'(tx));
        check({tag, ".rx"}, 32'(RX_READY), 32'(rx));
        check({tag, ".state"}, 32'(INIT_STATE), 32'(st));
    endtask

    initial begin
        RST           = 1'b1;
        PLL_LOCK      = 1'b1;
        TX_CLK_STABLE = 1'b1;
        RX_VAL        = 1'b1;
        cycles(2);
        check_outs("reset", 0, 0, 0, 0, 3'd0);
        check("reset.tcnt", 32'(TIMEOUT_CNT), 32'd0);

        // Nominal bring-up: PMA at edge 13, PCS 14, TX 16, RX 17
        @(negedge CLK);
        RST = 1'b0;
        cycles(4);
        check_outs("e4", 0, 0, 0, 0, 3'd1);
        cycles(8);
        check_outs("e12", 0, 0, 0, 0, 3'd2);
        cycles(1);
        check_outs("e13", 1, 0, 0, 0, 3'd3);
        cycles(1);
        check_outs("e14", 1, 1, 0, 0, 3'd4);
        cycles(1);
        check_outs("e15", 1, 1, 0, 0, 3'd4);
        cycles(1);
        check_outs("e16", 1, 1, 1, 0, 3'd5);
        cycles(1);
        check_outs("e17", 1, 1, 1, 1, 3'd6);

        // RX_VAL loss in RX_UP: RX_READY drops 3 cycles later, TX path untouched
        RX_VAL = 1'b0;
        cycles(2);
        check_outs("rxdrop2", 1, 1, 1, 1, 3'd6);
        cycles(1);
        check_outs("rxdrop3", 1, 1, 1, 0, 3'd5);
        RX_VAL = 1'b1;
        cycles(3);
        check_outs("rxback", 1, 1, 1, 1, 3'd6);

        // PLL lock loss in RX_UP: full reset within 3 cycles
        PLL_LOCK = 1'b0;
        cycles(2);
        check_outs("plldrop2", 1, 1, 1, 1, 3'd6);
        cycles(1);
        check_outs("plldrop3", 0, 0, 0, 0, 3'd0);

        // Lock returns; 1-cycle glitch seen at PLL_STABLE count 5 restarts the window
        PLL_LOCK = 1'b1;
        cycles(4);
        check_outs("rerun.wait", 0, 0, 0, 0, 3'd1);
        cycles(4);
        PLL_LOCK = 1'b0;
        cycles(1);
        PLL_LOCK = 1'b1;
        cycles(2);
        check_outs("glitch.wait", 0, 0, 0, 0, 3'd1);
        cycles(1);
        check_outs("glitch.stable", 0, 0, 0, 0, 3'd2);
        cycles(7);
        check_outs("glitch.late", 0, 0, 0, 0, 3'd2);
        cycles(1);
        check_outs("glitch.pma", 1, 0, 0, 0, 3'd3);
        cycles(1);
        check_outs("pcs2", 1, 1, 0, 0, 3'd4);

        // Asynchronous reset during RELEASE_PCS, checked before the next edge
        #2;
        RST = 1'b1;
        #1;
        check_outs("asyncrst", 0, 0, 0, 0, 3'd0);

        // TX clock never stabilises: PMA high exactly 10 cycles, then timeout
        TX_CLK_STABLE = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        cycles(13);
        check_outs("to.pma_rise", 1, 0, 0, 0, 3'd3);
        check("to.tcnt0", 32'(TIMEOUT_CNT), 32'd0);
        cycles(9);
        check_outs("to.pma_hold", 1, 0, 0, 0, 3'd3);
        cycles(1);
        check_outs("to.expire", 0, 0, 0, 0, 3'd0);
        check("to.tcnt1", 32'(TIMEOUT_CNT), CntEn ? 32'd1 : 32'd0);

        // Each further timeout loop is 4 + 1 + 8 + 10 = 23 cycles
        cycles(23 * 253);
        check("to.tcnt254", 32'(TIMEOUT_CNT), CntEn ? 32'd254 : 32'd0);
        check("to.state254", 32'(INIT_STATE), 32'd0);
        cycles(23);
        check("to.tcnt255", 32'(TIMEOUT_CNT), CntEn ? 32'd255 : 32'd0);
        cycles(23 * 45);
        check("to.tcnt300", 32'(TIMEOUT_CNT), CntEn ? 32'd255 : 32'd0);
        check_outs("to.end", 0, 0, 0, 0, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
